// File: rtl/ps2_host_transmitter_if.sv
// Host-side command handshake of the PS/2 transmitter: command byte and
// request in, busy and one-cycle result pulses out.
interface ps2_host_transmitter_if;
    logic [7:0] the_command;
    logic       send_command;
    logic       busy;
    logic       command_was_sent;
    logic       error_communication_timed_out;

    modport master (
        output the_command,
        output send_command,
        input  busy,
        input  command_was_sent,
        input  error_communication_timed_out
    );

    modport slave (
        input  the_command,
        input  send_command,
        output busy,
        output command_was_sent,
        output error_communication_timed_out
    );
endinterface

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device byte transmitter: request-to-send, bit shifting on device
// falling edges, ack check and timeout supervision. Lines are open-drain.
//
// state     | meaning
// IDLE      | both lines released, waiting for send_command
// HOLD_CLK  | PS2_CLK held low to request-to-send
// START_BIT | both lines low for one cycle
// WAIT_CLK  | CLK released, DAT low (start bit), waiting for first device edge
// TX_BITS   | data, parity, stop driven on successive device falling edges
// WAIT_ACK  | DAT released, device ack sampled on next falling edge
// DONE      | one-cycle success pulse
// ERROR     | one-cycle timeout / missing-ack pulse
module ps2_host_transmitter #(
    parameter int unsigned HOLD_CLK_CYCLES = 6000,
    parameter int unsigned WAIT_CLK_CYCLES = 750000,
    parameter int unsigned XFER_CYCLES     = 100000
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    ps2_host_transmitter_if.slave  host,
    inout  wire                    PS2_CLK,
    inout  wire                    PS2_DAT
);
    localparam int unsigned TMAX_HW = (HOLD_CLK_CYCLES > WAIT_CLK_CYCLES) ? HOLD_CLK_CYCLES : WAIT_CLK_CYCLES;
    localparam int unsigned TMAX    = (TMAX_HW > XFER_CYCLES) ? TMAX_HW : XFER_CYCLES;
    localparam int unsigned TW      = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD_CLK,
        S_START_BIT,
        S_WAIT_CLK,
        S_TX_BITS,
        S_WAIT_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          parity_q, parity_d;
    logic          clk_low_q, clk_low_d;
    logic          dat_low_q, dat_low_d;
    logic          busy_q, busy_d;
    logic          sent_q, sent_d;
    logic          err_q, err_d;
    logic [2:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          clk_fall;
    logic          dat_synced;

    // [1] is the synchronized level, [2] its previous value for edge detection.
    assign clk_fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign dat_synced = dat_sync_q[1];

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        parity_d   = parity_q;
        clk_sync_d = {clk_sync_q[1:0], PS2_CLK};
        dat_sync_d = {dat_sync_q[0], PS2_DAT};

        case (state_q)
            S_IDLE: begin
                if (host.send_command) begin
                    data_d   = host.the_command;
                    parity_d = ~^host.the_command;
                    timer_d  = TW'(HOLD_CLK_CYCLES - 1);
                    state_d  = S_HOLD_CLK;
                end
            end
            S_HOLD_CLK: begin
                if (timer_q == '0) begin
                    state_d = S_START_BIT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_START_BIT: begin
                timer_d = TW'(WAIT_CLK_CYCLES - 1);
                state_d = S_WAIT_CLK;
            end
            S_WAIT_CLK: begin
                if (clk_fall) begin
                    // first edge puts data bit 0 on the line and starts the transfer timer
                    bit_cnt_d = '0;
                    timer_d   = TW'(XFER_CYCLES - 1);
                    state_d   = S_TX_BITS;
                end else if (timer_q == '0) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_TX_BITS: begin
                if (timer_q == '0) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q - TW'(1);
                    if (clk_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d = S_WAIT_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end
            S_WAIT_ACK: begin
                if (timer_q == '0) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q - TW'(1);
                    if (clk_fall) begin
                        state_d = dat_synced ? S_ERROR : S_DONE;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        clk_low_d = (state_d == S_HOLD_CLK) || (state_d == S_START_BIT);
        case (state_d)
            S_START_BIT, S_WAIT_CLK: dat_low_d = 1'b1;
            S_TX_BITS:               dat_low_d = ~(bit_cnt_d[3] ? parity_d : data_d[bit_cnt_d[2:0]]);
            default:                 dat_low_d = 1'b0;
        endcase
        busy_d = (state_d != S_IDLE);
        sent_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            clk_low_q  <= 1'b0;
            dat_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
            err_q      <= 1'b0;
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            clk_low_q  <= clk_low_d;
            dat_low_q  <= dat_low_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
            err_q      <= err_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
        end
    end

    assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

    assign host.busy                          = busy_q;
    assign host.command_was_sent              = sent_q;
    assign host.error_communication_timed_out = err_q;
endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a PS/2 device model clocks frames out of the
// host, frames and outcomes are compared against a frame model and fixed vectors.
module tb_ps2_host_transmitter;
    localparam int HOLD     = 20;
    localparam int WAIT     = 200;
    localparam int XFER     = 600;
    // pin change -> two synchronizer flops -> state register
    localparam int SYNC_LAT = 3;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    wire  ps2_clk;
    wire  ps2_dat;

    ps2_host_transmitter_if bus ();

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_host_transmitter #(
        .HOLD_CLK_CYCLES(HOLD),
        .WAIT_CLK_CYCLES(WAIT),
        .XFER_CYCLES    (XFER)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .host    (bus),
        .PS2_CLK (ps2_clk),
        .PS2_DAT (ps2_dat)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int n_ok = 0;
    int n_err = 0;
    int pulse_cyc = 0;
    int busy_fall_cyc = 0;
    bit both_seen = 1'b0;
    bit long_seen = 1'b0;
    bit ok_prev = 1'b0;
    bit err_prev = 1'b0;
    bit busy_prev = 1'b0;

    always @(negedge CLOCK_50) begin
        if (bus.command_was_sent) begin n_ok++; pulse_cyc = cyc; end
        if (bus.error_communication_timed_out) begin n_err++; pulse_cyc = cyc; end
        if (bus.command_was_sent && bus.error_communication_timed_out) both_seen = 1'b1;
        if ((bus.command_was_sent && ok_prev) || (bus.error_communication_timed_out && err_prev))
            long_seen = 1'b1;
        if (busy_prev && !bus.busy) busy_fall_cyc = cyc;
        ok_prev   = bus.command_was_sent;
        err_prev  = bus.error_communication_timed_out;
        busy_prev = bus.busy;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [10:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0), b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] cmd);
        @(negedge CLOCK_50);
        bus.the_command  = cmd;
        bus.send_command = 1'b1;
        @(negedge CLOCK_50);
        bus.send_command = 1'b0;
    endtask

    task automatic wait_clk_line(input string name, input logic val);
        int guard = 0;
        while (ps2_clk !== val && guard < 1000) begin
            @(negedge CLOCK_50);
            guard++;
        end
        check(name, int'(ps2_clk === val), 1);
    endtask

    task automatic run_xfer(input string tag, input logic [7:0] cmd, input int half,
                            input int n_edges, input bit ack_low, input bit resend,
                            input logic [10:0] exp_frame, input int exp_ok, input int timing);
        logic [10:0] frame;
        logic [10:0] mask;
        int ok0, err0, t_low, t_rel, t_first, guard;
        ok0 = n_ok;
        err0 = n_err;
        frame = '1;
        t_first = 0;
        send(cmd);
        wait_clk_line({tag, " clk_pulled_low"}, 1'b0);
        t_low = cyc;
        if (resend) send(~cmd);
        wait_clk_line({tag, " clk_released"}, 1'b1);
        t_rel = cyc;
        check({tag, " rts_low_cycles"}, t_rel - t_low, HOLD + 1);
        repeat (half) @(negedge CLOCK_50);
        frame[0] = ps2_dat;
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11) dev_dat_low = ack_low;
            if (e == 1) t_first = cyc;
            dev_clk_low = 1'b1;
            repeat (half) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            repeat (half) @(negedge CLOCK_50);
            if (e <= 10) frame[e] = ps2_dat;
        end
        dev_dat_low = 1'b0;
        guard = 0;
        while (n_ok == ok0 && n_err == err0 && guard < 4 * XFER) begin
            @(negedge CLOCK_50);
            guard++;
        end
        repeat (4) @(negedge CLOCK_50);
        mask = (n_edges >= 10) ? 11'h7FF : 11'((1 << (n_edges + 1)) - 1);
        check({tag, " frame"}, int'(frame & mask), int'(exp_frame & mask));
        check({tag, " success_pulses"}, n_ok - ok0, exp_ok);
        check({tag, " error_pulses"}, n_err - err0, 1 - exp_ok);
        check({tag, " busy_fall_after_pulse"}, busy_fall_cyc - pulse_cyc, 1);
        check({tag, " lines_released"}, int'({ps2_clk, ps2_dat}), 3);
        check({tag, " busy_idle"}, int'(bus.busy), 0);
        if (timing == 1) check({tag, " wait_timeout_cycles"}, pulse_cyc - t_rel, WAIT);
        if (timing == 2) check({tag, " xfer_timeout_cycles"}, pulse_cyc - t_first, XFER + SYNC_LAT);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        int          n_edges;
        bit          ack_low;
        bit          resend;
        logic [10:0] exp_frame;
        int          exp_ok;
        int          timing;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int ok0, err0;
        logic [7:0] rcmd;
        bit rack;

        vecs[0] = '{8'hED, 11, 1'b1, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1, 0};
        vecs[1] = '{8'hF4, 11, 1'b1, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0}, 1, 0};
        vecs[2] = '{8'h00, 11, 1'b1, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, 1, 0};
        vecs[3] = '{8'h5A, 11, 1'b0, 1'b0, {1'b1, 1'b1, 8'h5A, 1'b0}, 0, 0};
        vecs[4] = '{8'h3C,  0, 1'b1, 1'b0, {1'b1, 1'b1, 8'h3C, 1'b0}, 0, 1};
        vecs[5] = '{8'h96,  5, 1'b1, 1'b1, {1'b1, 1'b1, 8'h96, 1'b0}, 0, 2};

        bus.the_command  = 8'h00;
        bus.send_command = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("reset busy", int'(bus.busy), 0);
        check("reset sent", int'(bus.command_was_sent), 0);
        check("reset err", int'(bus.error_communication_timed_out), 0);
        check("reset lines", int'({ps2_clk, ps2_dat}), 3);

        // reset wins over a simultaneous send request
        bus.the_command  = 8'hAA;
        bus.send_command = 1'b1;
        @(negedge CLOCK_50);
        bus.send_command = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check("reset_vs_send busy", int'(bus.busy), 0);
        check("reset_vs_send clk", int'(ps2_clk), 1);

        for (int i = 0; i < 6; i++)
            run_xfer($sformatf("vec%0d", i), vecs[i].cmd, 10, vecs[i].n_edges, vecs[i].ack_low,
                     vecs[i].resend, vecs[i].exp_frame, vecs[i].exp_ok, vecs[i].timing);

        // reset while the host drives data bit 3 (a 0) after edge 4
        ok0 = n_ok;
        err0 = n_err;
        send(8'hA5);
        wait_clk_line("rst_mid clk_pulled_low", 1'b0);
        wait_clk_line("rst_mid clk_released", 1'b1);
        repeat (10) @(negedge CLOCK_50);
        for (int e = 1; e <= 3; e++) begin
            dev_clk_low = 1'b1;
            repeat (10) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            repeat (10) @(negedge CLOCK_50);
        end
        dev_clk_low = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        check("rst_mid bit3_driven", int'(ps2_dat), 0);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        check("rst_mid dat_released", int'(ps2_dat), 1);
        check("rst_mid busy", int'(bus.busy), 0);
        dev_clk_low = 1'b0;
        repeat (30) @(negedge CLOCK_50);
        check("rst_mid clk_released", int'(ps2_clk), 1);
        check("rst_mid no_pulses", (n_ok - ok0) + (n_err - err0), 0);
        run_xfer("after_reset_ff", 8'hFF, 10, 11, 1'b1, 1'b0, {1'b1, 1'b1, 8'hFF, 1'b0}, 1, 0);

        for (int i = 0; i < 16; i++) begin
            rcmd = 8'($urandom);
            rack = ($urandom_range(3, 0) != 0);
            run_xfer($sformatf("rand%0d_%02h", i, rcmd), rcmd, int'($urandom_range(12, 4)), 11,
                     rack, 1'b0, model_frame(rcmd), int'(rack), 0);
        end

        check("pulses_never_together", int'(both_seen), 0);
        check("pulses_single_cycle", int'(long_seen), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
